// File: rtl/hazard_unit_md.sv
// hazard_unit_md: hazard controller for the 5-stage cached RV32 pipeline,
// with a sequencer and scoreboard for one non-pipelined multi-cycle mul/div unit.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   Rs1D_i/Rs2D_i/RdD_i        decode-stage source/destination registers
//   RegWriteD_i, MdOpD_i       decode writes RdD / decode op is mul/div
//   Rs1E_i/Rs2E_i/RdE_i        execute-stage registers
//   ResultSrcE_i               01 = load in execute
//   PCSrcE_i                   non-zero = taken redirect
//   MdStartE_i, MdDivE_i       mul/div issue in execute, div latency select
//   RdM_i/RegWriteM_i          memory-stage destination
//   RdW_i/RegWriteW_i          writeback-stage destination
//   CacheStall_i               data cache miss
//   ForwardAE_o/ForwardBE_o    00 regfile, 10 M, 01 W
//   Stall*_o, Flush*_o         pipeline stall / flush controls
//   MdBusy_o, MdWbValid_o      sequencer busy, md result write this cycle
//   MdRd_o                     pending md destination (0 when idle)
//   MdOverrun_o                sticky: md op issued while the unit was busy
//   StallCycles_o              saturating count of StallFetch cycles
//
// Sequencer states
//   state  | meaning
//   IDLE   | no md op in flight
//   RUN    | md op executing, cnt counts down to 0 (LAT cycles total)
//   DONE   | result ready, written on first cycle without CacheStall

module hazard_unit_md #(
  parameter int REG_AW      = 5,
  parameter int MUL_LATENCY = 3,
  parameter int DIV_LATENCY = 33,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] Rs1D_i,
  input  logic [REG_AW-1:0] Rs2D_i,
  input  logic [REG_AW-1:0] RdD_i,
  input  logic              RegWriteD_i,
  input  logic              MdOpD_i,
  input  logic [REG_AW-1:0] Rs1E_i,
  input  logic [REG_AW-1:0] Rs2E_i,
  input  logic [REG_AW-1:0] RdE_i,
  input  logic [1:0]        ResultSrcE_i,
  input  logic [1:0]        PCSrcE_i,
  input  logic              MdStartE_i,
  input  logic              MdDivE_i,
  input  logic [REG_AW-1:0] RdM_i,
  input  logic [REG_AW-1:0] RdW_i,
  input  logic              RegWriteM_i,
  input  logic              RegWriteW_i,
  input  logic              CacheStall_i,
  output logic [1:0]        ForwardAE_o,
  output logic [1:0]        ForwardBE_o,
  output logic              StallFetch_o,
  output logic              StallDecode_o,
  output logic              StallExecute_o,
  output logic              StallMemory_o,
  output logic              FlushDecode_o,
  output logic              FlushExecute_o,
  output logic              FlushWriteback_o,
  output logic              MdBusy_o,
  output logic              MdWbValid_o,
  output logic [REG_AW-1:0] MdRd_o,
  output logic              MdOverrun_o,
  output logic [CNT_W-1:0]  StallCycles_o
);

  localparam int LAT_MAX = (DIV_LATENCY > MUL_LATENCY) ? DIV_LATENCY : MUL_LATENCY;
  localparam int CW      = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
  localparam logic [CW-1:0] MUL_LD = CW'(MUL_LATENCY - 1);
  localparam logic [CW-1:0] DIV_LD = CW'(DIV_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } md_state_e;

  md_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [REG_AW-1:0] pend_rd_q, pend_rd_d;
  logic              overrun_q, overrun_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic accept;
  logic busy;
  logic load_use;
  logic md_hazard;
  logic pend_live;

  // Forwarding: x0 never forwards, M beats W.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if (src != '0) begin
      if (RegWriteM_i && (src == RdM_i))      sel = 2'b10;
      else if (RegWriteW_i && (src == RdW_i)) sel = 2'b01;
    end
    return sel;
  endfunction

  assign ForwardAE_o = fwd_sel(Rs1E_i);
  assign ForwardBE_o = fwd_sel(Rs2E_i);

  // Sequencer
  assign accept = MdStartE_i & ~CacheStall_i;
  assign busy   = (state_q != S_IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_rd_d = pend_rd_q;
    // A second issue while busy is dropped, only flagged.
    overrun_d = overrun_q | (accept & busy);
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_RUN;
          cnt_d     = MdDivE_i ? DIV_LD : MUL_LD;
          pend_rd_d = RdE_i;
        end
      end
      S_RUN: begin
        // Counter ignores CacheStall: the md unit is not part of the frozen pipe.
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_DONE: begin
        if (!CacheStall_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pend_rd_q   <= '0;
      overrun_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_rd_q   <= pend_rd_d;
      overrun_q   <= overrun_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign MdBusy_o    = busy;
  assign MdWbValid_o = (state_q == S_DONE) & ~CacheStall_i;
  assign MdRd_o      = busy ? pend_rd_q : '0;
  assign MdOverrun_o = overrun_q;

  // Hazard detection
  assign load_use = (ResultSrcE_i == 2'b01) && (RdE_i != '0) &&
                    ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));

  assign pend_live = busy && (pend_rd_q != '0);

  assign md_hazard =
      (pend_live && ((pend_rd_q == Rs1D_i) || (pend_rd_q == Rs2D_i))) ||
      (pend_live && RegWriteD_i && (RdD_i == pend_rd_q)) ||
      (MdStartE_i && (RdE_i != '0) && ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i))) ||
      (MdOpD_i && (busy || MdStartE_i));

  always_comb begin
    StallFetch_o     = 1'b0;
    StallDecode_o    = 1'b0;
    StallExecute_o   = 1'b0;
    StallMemory_o    = 1'b0;
    FlushDecode_o    = 1'b0;
    FlushExecute_o   = 1'b0;
    FlushWriteback_o = 1'b0;
    if (CacheStall_i) begin
      StallFetch_o     = 1'b1;
      StallDecode_o    = 1'b1;
      StallExecute_o   = 1'b1;
      StallMemory_o    = 1'b1;
      FlushWriteback_o = 1'b1;
    end else if (load_use || md_hazard) begin
      StallFetch_o   = 1'b1;
      StallDecode_o  = 1'b1;
      FlushExecute_o = 1'b1;
    end else if (PCSrcE_i != 2'b00) begin
      FlushDecode_o  = 1'b1;
      FlushExecute_o = 1'b1;
    end
  end

  // Stall-cycle counter holds at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (StallFetch_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  assign StallCycles_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit_md.sv
module tb_hazard_unit_md;

  localparam int CW_TB = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteD, MdOpD, MdStartE, MdDivE, RegWriteM, RegWriteW, CacheStall;
  logic [1:0] ResultSrcE, PCSrcE;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallFetch, StallDecode, StallExecute, StallMemory;
  logic FlushDecode, FlushExecute, FlushWriteback;
  logic MdBusy, MdWbValid, MdOverrun;
  logic [4:0] MdRd;
  logic [CW_TB-1:0] StallCycles;

  hazard_unit_md #(.REG_AW(5), .MUL_LATENCY(3), .DIV_LATENCY(33), .CNT_W(CW_TB)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D_i(Rs1D), .Rs2D_i(Rs2D), .RdD_i(RdD), .RegWriteD_i(RegWriteD), .MdOpD_i(MdOpD),
    .Rs1E_i(Rs1E), .Rs2E_i(Rs2E), .RdE_i(RdE), .ResultSrcE_i(ResultSrcE), .PCSrcE_i(PCSrcE),
    .MdStartE_i(MdStartE), .MdDivE_i(MdDivE),
    .RdM_i(RdM), .RdW_i(RdW), .RegWriteM_i(RegWriteM), .RegWriteW_i(RegWriteW),
    .CacheStall_i(CacheStall),
    .ForwardAE_o(ForwardAE), .ForwardBE_o(ForwardBE),
    .StallFetch_o(StallFetch), .StallDecode_o(StallDecode),
    .StallExecute_o(StallExecute), .StallMemory_o(StallMemory),
    .FlushDecode_o(FlushDecode), .FlushExecute_o(FlushExecute), .FlushWriteback_o(FlushWriteback),
    .MdBusy_o(MdBusy), .MdWbValid_o(MdWbValid), .MdRd_o(MdRd), .MdOverrun_o(MdOverrun),
    .StallCycles_o(StallCycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [18:0] e;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  logic [CW_TB-1:0] sc_model = '0;

  localparam logic [3:0] ST_NONE = 4'b0000;
  localparam logic [3:0] ST_HZ   = 4'b1100;
  localparam logic [3:0] ST_FRZ  = 4'b1111;
  localparam logic [2:0] FL_NONE = 3'b000;
  localparam logic [2:0] FL_HZ   = 3'b010;
  localparam logic [2:0] FL_FRZ  = 3'b001;
  localparam logic [2:0] FL_BR   = 3'b110;

  // {fa, fb, SF SD SE SM, FD FE FW, busy, wbvalid, mdrd, overrun}
  function automatic logic [18:0] ev(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic [3:0] st, input logic [2:0] fl,
                                     input logic busy, input logic wb,
                                     input logic [4:0] rd, input logic ovr);
    return {fa, fb, st, fl, busy, wb, rd, ovr};
  endfunction

  task automatic idle();
    Rs1D = 0; Rs2D = 0; RdD = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteD = 0; MdOpD = 0; MdStartE = 0; MdDivE = 0; RegWriteM = 0; RegWriteW = 0;
    CacheStall = 0; ResultSrcE = 0; PCSrcE = 0;
  endtask

  // Inputs are already driven for this cycle; expectation goes in, outputs are
  // sampled before the next rising edge, then we move to the next falling edge.
  task automatic cyc(input string tag, input logic [18:0] e);
    exp_t item;
    logic [18:0] obs;
    item.tag = tag;
    item.e   = e;
    sb.push_back(item);
    #1;
    item = sb.pop_front();
    obs = {ForwardAE, ForwardBE, StallFetch, StallDecode, StallExecute, StallMemory,
           FlushDecode, FlushExecute, FlushWriteback, MdBusy, MdWbValid, MdRd, MdOverrun};
    tests++;
    assert (obs === item.e) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", item.tag, obs, item.e);
    end
    tests++;
    assert (StallCycles === sc_model) else begin
      fails++;
      $error("FAIL %s/stallcycles: observed %0d expected %0d", item.tag, StallCycles, sc_model);
    end
    if (item.e[14] && rst_n && (sc_model != '1)) sc_model = sc_model + 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    cyc("reset", ev(0, 0, ST_NONE, FL_NONE, 0, 0, 0, 0));
    rst_n = 1'b1;

    // Forwarding
    Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
    cyc("fwd_m_over_w", ev(2'b10, 0, ST_NONE, FL_NONE, 0, 0, 0, 0));
    Rs1E = 0;
    cyc("fwd_x0", ev(0, 0, ST_NONE, FL_NONE, 0, 0, 0, 0));
    Rs1E = 5; RegWriteM = 0;
    cyc("fwd_w", ev(2'b01, 0, ST_NONE, FL_NONE, 0, 0, 0, 0));
    Rs1E = 7; Rs2E = 5; RegWriteM = 1;
    cyc("fwd_b_m", ev(0, 2'b10, ST_NONE, FL_NONE, 0, 0, 0, 0));
    RegWriteM = 0; RdW = 6;
    cyc("fwd_b_none", ev(0, 0, ST_NONE, FL_NONE, 0, 0, 0, 0));

    // Mul latency with RAW on decode
    idle(); Rs1D = 7; MdStartE = 1; RdE = 7;
    cyc("mul_issue", ev(0, 0, ST_HZ, FL_HZ, 0, 0, 0, 0));
    MdStartE = 0; RdE = 0;
    for (int i = 0; i < 3; i++) cyc("mul_run", ev(0, 0, ST_HZ, FL_HZ, 1, 0, 7, 0));
    cyc("mul_done", ev(0, 0, ST_HZ, FL_HZ, 1, 1, 7, 0));
    cyc("mul_release", ev(0, 0, ST_NONE, FL_NONE, 0, 0, 0, 0));

    // Structural, WAW, and overrun while busy
    idle(); MdStartE = 1; RdE = 9;
    cyc("ws_issue", ev(0, 0, ST_NONE, FL_NONE, 0, 0, 0, 0));
    MdStartE = 0; RdE = 0; MdOpD = 1;
    cyc("struct", ev(0, 0, ST_HZ, FL_HZ, 1, 0, 9, 0));
    MdOpD = 0; RegWriteD = 1; RdD = 9; MdStartE = 1;
    cyc("waw", ev(0, 0, ST_HZ, FL_HZ, 1, 0, 9, 0));
    MdStartE = 0; RdD = 0;
    cyc("waw_x0", ev(0, 0, ST_NONE, FL_NONE, 1, 0, 9, 1));
    RegWriteD = 0;
    cyc("ovr_done", ev(0, 0, ST_NONE, FL_NONE, 1, 1, 9, 1));
    cyc("ovr_idle", ev(0, 0, ST_NONE, FL_NONE, 0, 0, 0, 1));

    // Div with CacheStall held over DONE
    idle(); MdStartE = 1; MdDivE = 1; RdE = 3;
    cyc("div_issue", ev(0, 0, ST_NONE, FL_NONE, 0, 0, 0, 1));
    MdStartE = 0; MdDivE = 0; RdE = 0;
    for (int i = 0; i < 33; i++) cyc("div_run", ev(0, 0, ST_NONE, FL_NONE, 1, 0, 3, 1));
    CacheStall = 1;
    for (int i = 0; i < 3; i++) cyc("div_frz", ev(0, 0, ST_FRZ, FL_FRZ, 1, 0, 3, 1));
    CacheStall = 0;
    cyc("div_wb", ev(0, 0, ST_NONE, FL_NONE, 1, 1, 3, 1));
    cyc("div_idle", ev(0, 0, ST_NONE, FL_NONE, 0, 0, 0, 1));

    // Priority
    idle(); ResultSrcE = 2'b01; RdE = 4; Rs2D = 4; PCSrcE = 2'b01; CacheStall = 1;
    cyc("prio_frz", ev(0, 0, ST_FRZ, FL_FRZ, 0, 0, 0, 1));
    CacheStall = 0;
    cyc("prio_lu", ev(0, 0, ST_HZ, FL_HZ, 0, 0, 0, 1));
    RdE = 0; Rs2D = 0;
    cyc("lu_x0", ev(0, 0, ST_NONE, FL_BR, 0, 0, 0, 1));
    ResultSrcE = 0;
    cyc("prio_br", ev(0, 0, ST_NONE, FL_BR, 0, 0, 0, 1));

    // Reset in the middle of a div
    idle(); MdStartE = 1; MdDivE = 1; RdE = 6;
    cyc("rst_issue", ev(0, 0, ST_NONE, FL_NONE, 0, 0, 0, 1));
    MdStartE = 0; MdDivE = 0; RdE = 0;
    for (int i = 0; i < 2; i++) cyc("rst_run", ev(0, 0, ST_NONE, FL_NONE, 1, 0, 6, 1));
    rst_n = 1'b0;
    sc_model = '0;
    cyc("rst_mid", ev(0, 0, ST_NONE, FL_NONE, 0, 0, 0, 0));
    cyc("rst_hold", ev(0, 0, ST_NONE, FL_NONE, 0, 0, 0, 0));
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) cyc("rst_after", ev(0, 0, ST_NONE, FL_NONE, 0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
